// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller at the MEM->WB boundary.
// Picks the highest-priority exception (or ERET) of the committing instruction,
// raises a one-cycle event toward CP0 together with a pipeline flush, and then
// holds a PC redirect toward fetch until fetch accepts it.
module exc_commit_ctrl #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
    parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_if_adel,
    input  logic        m_ri,
    input  logic        m_ov,
    input  logic        m_sys,
    input  logic        m_bp,
    input  logic        m_eret,
    input  logic        m_d_adel,
    input  logic        m_d_ades,
    input  logic [31:0] m_daddr,
    input  logic        cp0_int_resp,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic [4:0]  exc_excode,
    output logic        exc_bd,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    output logic        exc_eret,
    output logic        flush,
    output logic        m_stall,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [31:0] redirPc_q;
    logic [31:0] redirPc_d;

    logic        anyExc;
    logic        fire;
    logic        isEret;
    logic [4:0]  selCode;
    logic [31:0] selBad;
    logic [31:0] epcCalc;
    logic [31:0] excVector;

    // Only the BEV bit of Status matters here; the rest is deliberately dropped.
    logic unusedStatus;
    assign unusedStatus = ^{cp0_status[31:23], cp0_status[21:0]};

    // Priority decode of the committing instruction and the CP0 event bus.
    always_comb begin
        anyExc    = cp0_int_resp | m_if_adel | m_ri | m_ov | m_sys | m_bp
                  | m_d_adel | m_d_ades;
        fire      = (state_q == IDLE) & m_valid & (anyExc | m_eret);
        isEret    = 1'b0;
        selCode   = 5'h00;
        selBad    = 32'h0;
        epcCalc   = m_bd ? (m_pc - 32'd4) : m_pc;
        excVector = cp0_status[22] ? VEC_BEV1 : VEC_BEV0;

        if (cp0_int_resp) begin
            selCode = 5'h00;
        end else if (m_if_adel) begin
            selCode = 5'h04;
            selBad  = m_pc;
        end else if (m_ri) begin
            selCode = 5'h0A;
        end else if (m_ov) begin
            selCode = 5'h0C;
        end else if (m_sys) begin
            selCode = 5'h08;
        end else if (m_bp) begin
            selCode = 5'h09;
        end else if (m_d_adel) begin
            selCode = 5'h04;
            selBad  = m_daddr;
        end else if (m_d_ades) begin
            selCode = 5'h05;
            selBad  = m_daddr;
        end else begin
            isEret  = m_eret;
        end

        exc_valid    = fire;
        flush        = fire;
        exc_eret     = fire & isEret;
        exc_excode   = (fire & ~isEret) ? selCode : 5'h00;
        exc_bd       = fire & ~isEret & m_bd;
        exc_epc      = fire ? epcCalc : 32'h0;
        exc_badvaddr = (fire & ~isEret) ? selBad : 32'h0;

        m_stall      = (state_q == REDIR);
        redir_valid  = (state_q == REDIR);
        redir_pc     = (state_q == REDIR) ? redirPc_q : 32'h0;
    end

    // Next-state and redirect-target capture; target uses pre-update CP0 values.
    always_comb begin
        state_d   = state_q;
        redirPc_d = redirPc_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d   = REDIR;
                    redirPc_d = isEret ? cp0_epc : excVector;
                end
            end
            REDIR: begin
                if (redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and redirect-target registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            redirPc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            redirPc_q <= redirPc_d;
        end
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
Exception/interrupt commit controller at the MEM→WB boundary, directly upstream of the CP0 register block. It prioritises the per-instruction exception flags carried down the pipeline and the CP0 interrupt-response line. It drives the one-cycle exception/ERET event bus into CP0, the pipeline flush, and a held PC-redirect request to fetch with a valid/ready handshake. Commit is blocked until fetch accepts the redirect.

Parameters:
VEC_BEV1  32'hBFC00380  exception entry vector when Status.BEV=1
VEC_BEV0  32'h80000180  exception entry vector when Status.BEV=0

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
m_valid  in  1  MEM-stage instruction valid, committing this cycle unless m_stall
m_pc  in  32  MEM-stage instruction PC
m_bd  in  1  instruction is in a branch delay slot
m_if_adel  in  1  fetch address error (PC misaligned)
m_ri  in  1  reserved instruction
m_ov  in  1  arithmetic overflow
m_sys  in  1  SYSCALL
m_bp  in  1  BREAK
m_eret  in  1  ERET
m_d_adel  in  1  load address error
m_d_ades  in  1  store address error
m_daddr  in  32  data virtual address
cp0_int_resp  in  1  CP0 interrupt response (unmasked, EXL=0, IE=1)
cp0_status  in  32  CP0 Status (bit 22 = BEV)
cp0_epc  in  32  CP0 EPC
exc_valid  out  1  to CP0: exception or ERET event
exc_excode  out  5  to CP0: ExcCode
exc_bd  out  1  to CP0: branch delay flag
exc_epc  out  32  to CP0: EPC value
exc_badvaddr  out  32  to CP0: BadVAddr value
exc_eret  out  1  to CP0: event is ERET
flush  out  1  kill all younger instructions (IF..MEM)
m_stall  out  1  hold MEM stage; no commit
redir_valid  out  1  redirect request to fetch
redir_pc  out  32  redirect target
redir_ready  in  1  fetch accepts redirect

Behaviour:
- States: IDLE, REDIR. Reset → IDLE. All outputs 0 in reset and in IDLE with no event. redir_pc and the captured event registers are also reset to 0.
- Trigger (IDLE only): hit = m_valid & (cp0_int_resp | any exc flag | m_eret).
- Priority, highest first, with ExcCode and BadVAddr:
  - Int: 0x00
  - if_adel: 0x04, BadVAddr = m_pc
  - ri: 0x0A
  - ov: 0x0C
  - sys: 0x08
  - bp: 0x09
  - d_adel: 0x04, BadVAddr = m_daddr
  - d_ades: 0x05, BadVAddr = m_daddr
  - eret
- ERET is taken only if no higher-priority source is set.
- Any non-Int source that is not an address error drives exc_badvaddr = 0.
- Interrupt attaches to the committing instruction. That instruction does not commit; EPC points at it.
- exc_epc = m_bd ? m_pc - 32'd4 : m_pc (32-bit wrap). exc_bd = m_bd.
- For ERET: exc_eret = 1, exc_excode = 0, exc_bd = 0.
- Event outputs are combinational in the hit cycle of IDLE. exc_valid and flush are high for exactly that one cycle.
- On hit the target is captured into redir_pc:
  - exception: cp0_status[22] ? VEC_BEV1 : VEC_BEV0
  - ERET: cp0_epc
- Target is sampled in the hit cycle (pre-update CP0 values), then IDLE → REDIR.
- REDIR:
  - redir_valid = 1 and m_stall = 1.
  - redir_pc is held stable until handshake.
  - m_* inputs and cp0_int_resp are ignored; no exc_valid.
- Handshake: redir_valid & redir_ready → REDIR → IDLE next cycle; redir_valid drops that edge.
- Latency: hit at cycle N → redir_valid from N+1. If redir_ready is already high at N+1, a new commit is possible at N+2.
- m_stall in IDLE is 0, including the hit cycle. In the hit cycle the MEM instruction is suppressed by flush, not stalled.
- Multiple simultaneous flags: only the highest-priority one is reported.
- m_valid = 0 masks everything, including cp0_int_resp.
- Reset mid-REDIR: synchronous return to IDLE; redir_valid and m_stall are 0 the next cycle.

Test Plan:
- Overflow, BEV=1: m_valid=1, m_ov=1, m_pc=0xBFC00100, m_bd=0, status[22]=1.
  -> exc_valid 1 cycle, excode=0x0C, epc=0xBFC00100, flush 1 cycle; next cycle redir_valid=1, redir_pc=0xBFC00380.
- Delay-slot store error: m_d_ades=1, m_bd=1, m_pc=0x80001004, m_daddr=0x80002001, BEV=0.
  -> excode=0x05, epc=0x80001000, badvaddr=0x80002001, exc_bd=1, redir_pc=0x80000180.
- Priority: cp0_int_resp=1 together with m_ri=1 and m_sys=1.
  -> excode=0x00; then drop int_resp with ri+sys -> excode=0x0A.
- ERET: m_eret=1, cp0_epc=0xBFC00ABC.
  -> exc_valid=1, exc_eret=1, redir_pc=0xBFC00ABC.
  Also m_eret with m_if_adel -> excode=0x04, exc_eret=0.
- Handshake hold: redir_ready low for 5 cycles while new m_ov pulses arrive.
  -> redir_valid/pc stable, m_stall=1, no exc_valid; ready=1 -> IDLE next cycle.
- Reset while in REDIR: resetn=0 for one cycle.
  -> redir_valid=0, m_stall=0, state IDLE; m_valid=0 with int_resp=1 -> no event.
